// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter sharing one bit-serial link between NREQ requesters.
// Ports: clk, rst(sync low), req, data -> gnt, owner, ser_out, ser_vld, busy, done.
// Optional: SERIAL_LINK_ARB_PARITY_EN appends an even-parity bit to each frame.
module serial_link_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 6,
  parameter int GAP_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic [1:0]            owner,
  output logic                  ser_out,
  output logic                  ser_vld,
  output logic                  busy,
  output logic                  done
);

`ifdef SERIAL_LINK_ARB_PARITY_EN
  localparam int LEN = WIDTH + 1;
`else
  localparam int LEN = WIDTH;
`endif
  localparam int CW = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  sh, sh_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [NREQ-1:0]   gnt_n;
  logic [1:0]        owner_n, last, last_n;
  logic              ser_out_n, ser_vld_n;
  logic              busy_n, done_n;
`ifdef SERIAL_LINK_ARB_PARITY_EN
  logic              par, par_n;
`endif

  logic              hit;
  logic [1:0]        win;
  logic [WIDTH-1:0]  word;
  int                idx;

  // first asserted request after the last owner, wrapping
  always_comb begin
    hit  = 1'b0;
    win  = last;
    word = '0;
    idx  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && req[idx]) begin
        hit  = 1'b1;
        win  = 2'(idx);
        word = data[idx*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_n   = state;
    sh_n      = sh;
    cnt_n     = cnt;
    gnt_n     = '0;
    owner_n   = owner;
    last_n    = last;
    ser_out_n = ser_out;
    ser_vld_n = ser_vld;
    busy_n    = busy;
    done_n    = 1'b0;
`ifdef SERIAL_LINK_ARB_PARITY_EN
    par_n     = par;
`endif
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_n   = SHIFT;
          sh_n      = word << 1;
          ser_out_n = word[WIDTH-1];
          ser_vld_n = 1'b1;
          busy_n    = 1'b1;
          gnt_n     = NREQ'(1) << win;
          owner_n   = win;
          last_n    = win;
          cnt_n     = '0;
`ifdef SERIAL_LINK_ARB_PARITY_EN
          par_n     = ^word;
`endif
        end
      end
      SHIFT: begin
        if (cnt == CW'(LEN - 1)) begin
          ser_vld_n = 1'b0;
          ser_out_n = 1'b0;
          cnt_n     = '0;
          if (GAP_CYC > 0) begin
            state_n = GAP;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n     = cnt + CW'(1);
          sh_n      = sh << 1;
          ser_out_n = sh[WIDTH-1];
`ifdef SERIAL_LINK_ARB_PARITY_EN
          if (cnt == CW'(WIDTH - 1)) ser_out_n = par;
`endif
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYC - 1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      gnt     <= '0;
      owner   <= '0;
      last    <= 2'(NREQ - 1);
      ser_out <= 1'b0;
      ser_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIAL_LINK_ARB_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      owner   <= owner_n;
      last    <= last_n;
      ser_out <= ser_out_n;
      ser_vld <= ser_vld_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef SERIAL_LINK_ARB_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Bench for serial_link_arbiter: vector table, directed corner
// sequences and random traffic against a frame-position model.
module tb_serial_link_arbiter;
  localparam int NREQ = 2;
  localparam int W    = 6;
  localparam int G    = 2;
`ifdef SERIAL_LINK_ARB_PARITY_EN
  localparam int LEN = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int LEN = W;
  localparam bit PAR = 1'b0;
`endif
  localparam int PERIOD = LEN + G + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] data;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        owner;
  logic              ser_out, ser_vld, busy, done;

  serial_link_arbiter #(.NREQ(NREQ), .WIDTH(W), .GAP_CYC(G)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .gnt(gnt), .owner(owner), .ser_out(ser_out),
    .ser_vld(ser_vld), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model: position within frame (-1 idle, LEN+G is the done cycle)
  int         m_pos = -1;
  logic [W-1:0] m_word = '0;
  int         m_owner = 0;
  int         m_last = NREQ - 1;

  always @(posedge clk) begin
    if (!rst) begin
      m_pos = -1;
      m_owner = 0;
      m_last = NREQ - 1;
    end else if (m_pos == -1 || m_pos == LEN + G) begin
      m_pos = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_last + k) % NREQ;
        if (m_pos == -1 && req[j]) begin
          m_pos = 0;
          m_owner = j;
          m_last = j;
          m_word = data[j*W +: W];
        end
      end
    end else begin
      m_pos++;
    end
  end

  function automatic logic exp_sout();
    if (m_pos >= 0 && m_pos < W) return m_word[W-1-m_pos];
    if (PAR && m_pos == W) return ^m_word;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic [NREQ-1:0] eg;
    @(posedge clk);
    #1;
    cyc++;
    eg = (m_pos == 0) ? NREQ'(1) << m_owner : '0;
    chk("m_gnt", 32'(gnt), 32'(eg));
    chk("m_owner", 32'(owner), 32'(m_owner));
    chk("m_sout", 32'(ser_out), 32'(exp_sout()));
    chk("m_svld", 32'(ser_vld), 32'(m_pos >= 0 && m_pos < LEN));
    chk("m_busy", 32'(busy), 32'(m_pos >= 0 && m_pos < LEN + G));
    chk("m_done", 32'(done), 32'(m_pos == LEN + G));
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       so, sv, bz, dn;
  } vec_t;
  vec_t tab[$];

  task automatic add(input logic r, input logic [1:0] q, input logic [1:0] g,
                     input logic so, input logic sv, input logic bz,
                     input logic dn);
    vec_t v;
    v.rst = r; v.req = q; v.gnt = g;
    v.so = so; v.sv = sv; v.bz = bz; v.dn = dn;
    tab.push_back(v);
  endtask

  initial begin
    int gcyc[$];
    logic [1:0] gval[$];
    int gown[$];
    int ng, nd;

    rst = 1'b0;
    req = '0;
    data = {6'b010011, 6'b101100};

    add(0, 2'b11, 2'b00, 0, 0, 0, 0);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0);
    add(0, 2'b11, 2'b00, 0, 0, 0, 0);
    add(1, 2'b11, 2'b01, 1, 1, 1, 0);
    add(1, 2'b00, 2'b00, 0, 1, 1, 0);
    add(1, 2'b00, 2'b00, 1, 1, 1, 0);
    add(1, 2'b00, 2'b00, 1, 1, 1, 0);
    add(1, 2'b00, 2'b00, 0, 1, 1, 0);
    add(1, 2'b00, 2'b00, 0, 1, 1, 0);
`ifdef SERIAL_LINK_ARB_PARITY_EN
    add(1, 2'b00, 2'b00, 1, 1, 1, 0);
`endif
    add(1, 2'b00, 2'b00, 0, 0, 1, 0);
    add(1, 2'b00, 2'b00, 0, 0, 1, 0);
    add(1, 2'b00, 2'b00, 0, 0, 0, 1);
    add(1, 2'b00, 2'b00, 0, 0, 0, 0);

    foreach (tab[i]) begin
      rst = tab[i].rst;
      req = tab[i].req;
      tick();
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tab[i].gnt));
      chk($sformatf("v%0d_sout", i), 32'(ser_out), 32'(tab[i].so));
      chk($sformatf("v%0d_svld", i), 32'(ser_vld), 32'(tab[i].sv));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tab[i].bz));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tab[i].dn));
      chk($sformatf("v%0d_owner", i), 32'(owner), 32'd0);
    end

    // fairness with both requests held after a reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 2'b11;
    for (int i = 0; i < 4 * PERIOD + 4; i++) begin
      tick();
      if (gnt != '0) begin
        gcyc.push_back(cyc);
        gval.push_back(gnt);
        gown.push_back(int'(owner));
      end
    end
    chk("fair_count_ge4", 32'(gcyc.size() >= 4), 32'd1);
    if (gcyc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("fair_gnt%0d", i), 32'(gval[i]),
            (i % 2 == 0) ? 32'h1 : 32'h2);
        chk($sformatf("fair_own%0d", i), 32'(gown[i]), 32'(i % 2));
        if (i > 0)
          chk($sformatf("fair_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]),
              32'(PERIOD));
      end
    end

    // drain, then ignored request pulse and mid-frame drop
    req = 2'b00;
    repeat (PERIOD + 2) tick();
    req = 2'b01;
    tick();
    chk("ign_gnt", 32'(gnt), 32'h1);
    req = 2'b11;
    tick();
    req = 2'b01;
    tick();
    tick();
    req = 2'b00;
    ng = 0;
    nd = 0;
    for (int i = 0; i < PERIOD + 6; i++) begin
      tick();
      if (gnt != '0) ng++;
      if (done) nd++;
    end
    chk("ign_no_grant", 32'(ng), 32'd0);
    chk("ign_one_done", 32'(nd), 32'd1);

    // reset after the third bit
    req = 2'b10;
    tick();
    chk("rmf_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rmf_svld", 32'(ser_vld), 32'd0);
    chk("rmf_busy", 32'(busy), 32'd0);
    chk("rmf_done", 32'(done), 32'd0);
    chk("rmf_sout", 32'(ser_out), 32'd0);
    rst = 1'b1;
    req = 2'b11;
    tick();
    chk("rmf_first_gnt", 32'(gnt), 32'h1);
    chk("rmf_first_own", 32'(owner), 32'd0);
    req = 2'b00;
    repeat (PERIOD + 1) tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      req = NREQ'($urandom);
      data = (NREQ*W)'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_link_arbiter.md
Name: serial_link_arbiter

Overview:
- Round-robin controller that shares one bit-serial link between NREQ requesters.
- Each requester presents a parallel WIDTH-bit word. The block grants one requester per frame and shifts its word out MSB-first with a valid strobe, then inserts an inter-frame gap.
- Sits in front of the serial FSM/detector blocks and sequences their din stream.

Parameters:
- NREQ, 2, number of requesters (legal 2..4)
- WIDTH, 6, data bits per frame (legal 2..16)
- GAP_CYC, 2, idle cycles after each frame (legal 0..15)

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous, active-low reset (rst==0 resets on the next posedge)
- req  input  NREQ  per-requester request level
- data  input  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant pulse, one cycle
- owner  output  2  index of the requester currently or last granted
- ser_out  output  1  serial data, MSB first
- ser_vld  output  1  high while ser_out carries a frame bit
- busy  output  1  high from the grant cycle through the last gap cycle
- done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset values (rst==0 at a posedge): state=IDLE; gnt=0; ser_out=0; ser_vld=0; busy=0; done=0; owner=0; internal last-owner pointer=NREQ-1, so requester 0 has top priority after reset. All outputs are driven directly from registers.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - At a posedge with any req bit set, select the first set req searching from last+1 upward, wrapping at NREQ.
  - On that edge: load the selected word into the shift register, set gnt to one-hot of the winner, set owner and last to the winner, set busy=1, set ser_vld=1, and enter SHIFT.
  - data is sampled only on that edge.
- SHIFT:
  - Lasts WIDTH cycles. The first cycle is the gnt cycle and carries bit WIDTH-1; each following edge shifts left by one.
  - gnt returns to 0 after one cycle.
  - After the last bit: if GAP_CYC>0, go to GAP with ser_vld=0 and ser_out=0. Otherwise go to IDLE with busy=0 and done=1.
- GAP: stays GAP_CYC cycles with ser_out=0 and ser_vld=0, then goes to IDLE with busy=0 and done=1.
- done is high in the first IDLE cycle only.
  - Arbitration may fire on the edge that ends that cycle.
  - Minimum frame period is WIDTH+GAP_CYC+1 cycles.
- Requests:
  - req is level-sensitive and never queued.
  - Changes to req or data while busy are ignored. Frames always run to completion.
  - A requester that drops req before being granted is skipped.
- Fairness: with all req held high, grants rotate 0,1,…,NREQ-1,0. No requester is starved.
- Reset mid-frame: the next cycle shows reset values, with no partial bits and no done pulse.
- owner holds its value between frames.

Optional Feature:
- Macro: SERIAL_LINK_ARB_PARITY_EN.
- When defined: SHIFT lasts WIDTH+1 cycles. The extra final bit, with ser_vld=1, is even parity (XOR of the latched word), computed at load time. All later timing shifts by one cycle.
- When undefined: no parity bit, and the parity logic is absent.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=2'b11 → gnt=0, ser_vld=0, ser_out=0, busy=0, done=0, owner=0 throughout. Release → first grant is gnt=2'b01.
- Single frame: req=2'b01, data0=6'b101100. Taking the gnt cycle as c:
  - ser_out=1,0,1,1,0,0 with ser_vld=1 in cycles c..c+5
  - ser_vld=0 in cycles c+6 and c+7
  - done=1 in cycle c+8 only; busy=1 in cycles c..c+7
- Fairness: req=2'b11 held, data0=6'b101100, data1=6'b010011 → grants alternate 01,10,01,10, spaced exactly 9 cycles apart. owner alternates 0,1. Serial output matches each word.
- Ignored request: while requester 0 is busy, pulse req[1] for one cycle and drop it, then drop req[0] mid-frame → the frame completes normally and no grant follows.
- Reset mid-frame: assert rst=0 after the 3rd bit → ser_vld=0 and busy=0 next cycle, no done pulse. With req=2'b11 afterwards, requester 0 wins first.
- Parity (macro defined): data0=6'b101100 → 7 valid bits 1,0,1,1,0,0,1, then 2 gap cycles. done is at c+9.
